// File: rtl/mem_bus_arbiter.sv
// N-master / M-slave round-robin arbiter with address decode and 1-cycle response routing.
// Build option BUS_DECODE_ERR_EN: unmapped accesses respond with m_err=1 and a DEADBEEF pattern.
module mem_bus_arbiter #(
  parameter int unsigned                   NUM_MASTERS = 2,
  parameter int unsigned                   NUM_SLAVES  = 2,
  parameter int unsigned                   ADDR_W      = 32,
  parameter int unsigned                   DATA_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE  = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK  = {32'hFFFF_0000, 32'hFFFF_C000}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            m_err,
  output logic [NUM_SLAVES-1:0]           s_req,
  output logic [ADDR_W-1:0]               s_addr,
  output logic                            s_we,
  output logic [DATA_W/8-1:0]             s_be,
  output logic [DATA_W-1:0]               s_wdata,
  input  logic [NUM_SLAVES-1:0]           s_gnt,
  input  logic [NUM_SLAVES*DATA_W-1:0]    s_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned MW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

`ifdef BUS_DECODE_ERR_EN
  localparam logic              ERR_EN   = 1'b1;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);
`else
  localparam logic              ERR_EN   = 1'b0;
  localparam logic [DATA_W-1:0] ERR_DATA = '0;
`endif

  typedef enum logic {
    ST_FREE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [MW-1:0]          lock_mst_q, lock_mst_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
  logic [SW-1:0]          rslv_q, rslv_d;
  logic                   runmap_q, runmap_d;

  logic                   win_found;
  logic [MW-1:0]          win_idx;
  logic [MW-1:0]          cand_idx;
  int unsigned            cand;
  logic [ADDR_W-1:0]      win_addr;
  logic                   hit;
  logic [SW-1:0]          hit_idx;
  logic                   req_ok;
  logic                   granted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FREE;
      lock_mst_q <= '0;
      ptr_q      <= '0;
      rvalid_q   <= '0;
      rslv_q     <= '0;
      runmap_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_mst_q <= lock_mst_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= rvalid_d;
      rslv_q     <= rslv_d;
      runmap_q   <= runmap_d;
    end
  end

  // Arbitration, decode, grant and lock/pointer next-state.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = 0;
    cand_idx   = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    m_gnt      = '0;
    s_req      = '0;
    s_addr     = '0;
    s_we       = 1'b0;
    s_be       = '0;
    s_wdata    = '0;
    state_d    = state_q;
    lock_mst_d = lock_mst_q;
    ptr_d      = ptr_q;
    rvalid_d   = '0;
    rslv_d     = rslv_q;
    runmap_d   = runmap_q;

    if (state_q == ST_LOCK) begin
      win_found = m_req[lock_mst_q];
      win_idx   = lock_mst_q;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        cand     = (32'(ptr_q) + i) % NUM_MASTERS;
        cand_idx = MW'(cand);
        if (!win_found && m_req[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end

    win_addr = m_addr[32'(win_idx)*ADDR_W +: ADDR_W];
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (!hit && ((win_addr & SLAVE_MASK[s*ADDR_W +: ADDR_W]) == SLAVE_BASE[s*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = SW'(s);
      end
    end

    // Unmapped requests are accepted by the arbiter itself.
    req_ok  = win_found & rst_n;
    granted = req_ok & (~hit | s_gnt[hit_idx]);

    if (req_ok) begin
      if (hit) s_req[hit_idx] = 1'b1;
      s_addr  = win_addr;
      s_we    = m_we[win_idx];
      s_be    = m_be[32'(win_idx)*BE_W +: BE_W];
      s_wdata = m_wdata[32'(win_idx)*DATA_W +: DATA_W];
    end

    if (granted) begin
      m_gnt[win_idx]    = 1'b1;
      rvalid_d[win_idx] = 1'b1;
      rslv_d            = hit_idx;
      runmap_d          = ~hit;
      ptr_d             = (win_idx == MW'(NUM_MASTERS - 1)) ? '0 : win_idx + MW'(1);
    end

    case (state_q)
      ST_FREE: begin
        if (req_ok && !granted) begin
          state_d    = ST_LOCK;
          lock_mst_d = win_idx;
        end
      end
      ST_LOCK: begin
        if (granted || !req_ok) state_d = ST_FREE;
      end
      default: state_d = ST_FREE;
    endcase
  end

  // Response routing from the registered {master, slave, unmapped} tag.
  always_comb begin
    m_rvalid = rvalid_q;
    m_rdata  = '0;
    m_err    = 1'b0;
    if (|rvalid_q) begin
      if (runmap_q) begin
        m_rdata = ERR_DATA;
        m_err   = ERR_EN;
      end else begin
        m_rdata = s_rdata[32'(rslv_q)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model built from address ranges and a priority list.
module tb_mem_bus_arbiter;

  localparam int NM = 2;
`ifdef BUS_DECODE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [63:0] m_addr;
  logic [1:0]  m_we;
  logic [7:0]  m_be;
  logic [63:0] m_wdata;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [1:0]  s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic [1:0]  s_gnt;
  logic [63:0] s_rdata;

  int checks = 0;
  int failures = 0;

  int  ptr_m, lock_m, pend_m, pend_s, w_m, sl_m;
  bit  pend_v, g_m;
  logic [1:0]  exp_gnt, exp_sreq, exp_rvalid;
  logic [31:0] exp_rdata, exp_saddr, exp_swdata;
  logic        exp_err, exp_swe;
  logic [3:0]  exp_sbe;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rdata(s_rdata)
  );

  // Slave 0: 0x0000_0000..0x0000_3FFF, slave 1: 0x0001_0000..0x0001_FFFF.
  function automatic int decode(input logic [31:0] a);
    if (a < 32'h0000_4000) return 0;
    if (a >= 32'h0001_0000 && a < 32'h0002_0000) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    int kind;
    kind = $urandom_range(0, 2);
    if (kind == 0) return {18'h0, 14'($urandom)};
    if (kind == 1) return {16'h0001, 16'($urandom)};
    return 32'h2000_0000 | {8'h0, 24'($urandom)};
  endfunction

  task automatic model_eval();
    exp_gnt = '0; exp_sreq = '0; exp_rvalid = '0; exp_rdata = '0; exp_err = 1'b0;
    exp_saddr = '0; exp_swe = 1'b0; exp_sbe = '0; exp_swdata = '0;
    g_m = 1'b0; w_m = -1; sl_m = -1;
    if (rst_n) begin
      if (pend_v) begin
        exp_rvalid[pend_m] = 1'b1;
        if (pend_s < 0) begin
          exp_err   = ERR_EN;
          exp_rdata = ERR_EN ? 32'hDEAD_BEEF : 32'h0;
        end else begin
          exp_rdata = s_rdata[pend_s*32 +: 32];
        end
      end
      if (lock_m >= 0) begin
        if (m_req[lock_m]) w_m = lock_m;
      end else begin
        for (int k = 0; k < NM; k++) begin
          int c;
          c = (ptr_m + k) % NM;
          if (w_m < 0 && m_req[c]) w_m = c;
        end
      end
      if (w_m >= 0) begin
        sl_m = decode(m_addr[w_m*32 +: 32]);
        if (sl_m >= 0) exp_sreq[sl_m] = 1'b1;
        g_m = (sl_m < 0) || s_gnt[sl_m];
        if (g_m) exp_gnt[w_m] = 1'b1;
        exp_saddr  = m_addr[w_m*32 +: 32];
        exp_swe    = m_we[w_m];
        exp_sbe    = m_be[w_m*4 +: 4];
        exp_swdata = m_wdata[w_m*32 +: 32];
      end
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      ptr_m = 0; lock_m = -1; pend_v = 1'b0;
    end else begin
      pend_v = g_m;
      if (g_m) begin
        pend_m = w_m; pend_s = sl_m; ptr_m = (w_m + 1) % NM; lock_m = -1;
      end else begin
        lock_m = w_m;
      end
    end
  endtask

  task automatic settle();
    model_eval();
    #3;
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
    s_rdata = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_req = '0;
    model_eval();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    m_req = 2'b11; m_addr = {32'h0001_0000, 32'h0000_0004}; s_gnt = 2'b11;
    settle();
    if (m_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", m_gnt); end checks++;
    if (s_req !== 2'b00) begin failures++; $display("FAIL reset_sreq: got %b want 00", s_req); end checks++;
    if (m_rvalid !== 2'b00) begin failures++; $display("FAIL reset_rvalid: got %b want 00", m_rvalid); end checks++;
    if (m_err !== 1'b0 || m_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp: got err=%b rdata=%h want 0/0", m_err, m_rdata); end checks++;
    advance();
    rst_n = 1'b1; m_req = '0;
    settle();
    if (m_rvalid !== 2'b00) begin failures++; $display("FAIL reset_release_rvalid: got %b want 00", m_rvalid); end checks++;
    advance();
  endtask

  task automatic test_single_read();
    m_req = 2'b01; m_addr[31:0] = 32'h0000_0004; m_we = '0; s_gnt = 2'b11;
    settle();
    if (m_gnt !== 2'b01) begin failures++; $display("FAIL read_gnt: got %b want 01", m_gnt); end checks++;
    if (s_req !== 2'b01) begin failures++; $display("FAIL read_sreq: got %b want 01", s_req); end checks++;
    if (s_addr !== 32'h4) begin failures++; $display("FAIL read_saddr: got %h want 00000004", s_addr); end checks++;
    advance();
    m_req = '0;
    settle();
    if (m_rvalid !== 2'b01) begin failures++; $display("FAIL read_rvalid: got %b want 01", m_rvalid); end checks++;
    if (m_rdata !== s_rdata[31:0]) begin failures++; $display("FAIL read_rdata: got %h want %h", m_rdata, s_rdata[31:0]); end checks++;
    advance();
  endtask

  task automatic test_alternate();
    logic [1:0] prev;
    prev = 2'b00;
    m_req = 2'b11; m_addr = {32'h0001_0000, 32'h0001_0000}; s_gnt = 2'b11;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (m_gnt !== exp_gnt) begin failures++; $display("FAIL alt_gnt[%0d]: got %b want %b", c, m_gnt, exp_gnt); end checks++;
      if (c > 0 && m_gnt !== ~prev) begin failures++; $display("FAIL alt_toggle[%0d]: got %b want %b", c, m_gnt, ~prev); end checks++;
      if (m_rvalid !== exp_rvalid || m_rdata !== exp_rdata) begin failures++; $display("FAIL alt_resp[%0d]: got %b/%h want %b/%h", c, m_rvalid, m_rdata, exp_rvalid, exp_rdata); end checks++;
      prev = m_gnt;
      advance();
    end
    m_req = '0;
    settle();
    if (m_rvalid !== exp_rvalid) begin failures++; $display("FAIL alt_last_rvalid: got %b want %b", m_rvalid, exp_rvalid); end checks++;
    advance();
  endtask

  task automatic test_lock();
    do_reset();
    m_req = 2'b10; m_addr = {32'h0001_0000, 32'h0000_0000}; s_gnt = 2'b01;
    settle();
    if (m_gnt !== 2'b00 || s_req !== 2'b10) begin failures++; $display("FAIL lock_c1: got gnt=%b sreq=%b want 00/10", m_gnt, s_req); end checks++;
    advance();
    m_req = 2'b11;
    for (int c = 2; c <= 3; c++) begin
      settle();
      if (m_gnt !== 2'b00 || s_req !== 2'b10) begin failures++; $display("FAIL lock_hold[%0d]: got gnt=%b sreq=%b want 00/10", c, m_gnt, s_req); end checks++;
      advance();
    end
    s_gnt = 2'b11;
    settle();
    if (m_gnt !== 2'b10) begin failures++; $display("FAIL lock_release: got %b want 10", m_gnt); end checks++;
    advance();
    settle();
    if (m_gnt !== 2'b01 || m_rvalid !== 2'b10) begin failures++; $display("FAIL lock_next: got gnt=%b rvalid=%b want 01/10", m_gnt, m_rvalid); end checks++;
    advance();
    m_req = '0;
    settle();
    if (m_rvalid !== 2'b01) begin failures++; $display("FAIL lock_last_rvalid: got %b want 01", m_rvalid); end checks++;
    advance();
  endtask

  task automatic test_unmapped();
    m_req = 2'b01; m_addr[31:0] = 32'h2000_0000; s_gnt = 2'b00;
    settle();
    if (m_gnt !== 2'b01 || s_req !== 2'b00) begin failures++; $display("FAIL unmap_gnt: got gnt=%b sreq=%b want 01/00", m_gnt, s_req); end checks++;
    advance();
    m_req = '0;
    settle();
    if (m_rvalid !== 2'b01) begin failures++; $display("FAIL unmap_rvalid: got %b want 01", m_rvalid); end checks++;
    if (m_err !== ERR_EN) begin failures++; $display("FAIL unmap_err: got %b want %b", m_err, ERR_EN); end checks++;
    if (m_rdata !== (ERR_EN ? 32'hDEAD_BEEF : 32'h0)) begin failures++; $display("FAIL unmap_rdata: got %h want %h", m_rdata, ERR_EN ? 32'hDEAD_BEEF : 32'h0); end checks++;
    advance();
  endtask

  task automatic test_write();
    m_req = 2'b01; m_addr[31:0] = 32'h0000_0010; m_we = 2'b01; m_be[3:0] = 4'b0011;
    m_wdata[31:0] = 32'hA5A5_1234; s_gnt = 2'b01;
    settle();
    if (m_gnt !== 2'b01 || s_req !== 2'b01) begin failures++; $display("FAIL wr_gnt: got gnt=%b sreq=%b want 01/01", m_gnt, s_req); end checks++;
    if (s_we !== 1'b1 || s_be !== 4'b0011) begin failures++; $display("FAIL wr_ctl: got we=%b be=%b want 1/0011", s_we, s_be); end checks++;
    if (s_wdata !== 32'hA5A5_1234) begin failures++; $display("FAIL wr_data: got %h want a5a51234", s_wdata); end checks++;
    advance();
    m_req = '0; m_we = '0;
    settle();
    if (m_rvalid !== 2'b01) begin failures++; $display("FAIL wr_rvalid: got %b want 01", m_rvalid); end checks++;
    advance();
  endtask

  task automatic test_reset_mid();
    m_req = 2'b10; m_addr = {32'h0001_0004, 32'h0000_0000}; s_gnt = 2'b11;
    settle();
    if (m_gnt !== 2'b10) begin failures++; $display("FAIL rstmid_gnt: got %b want 10", m_gnt); end checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (m_gnt !== 2'b00 || s_req !== 2'b00) begin failures++; $display("FAIL rstmid_async: got gnt=%b sreq=%b want 00/00", m_gnt, s_req); end checks++;
    advance();
    m_req = '0;
    settle();
    if (m_rvalid !== 2'b00 || m_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_norsp: got %b/%h want 00/0", m_rvalid, m_rdata); end checks++;
    advance();
    rst_n = 1'b1;
    settle();
    if (m_rvalid !== 2'b00) begin failures++; $display("FAIL rstmid_release: got %b want 00", m_rvalid); end checks++;
    advance();
    m_req = 2'b11; m_addr = {32'h0001_0000, 32'h0000_0000};
    settle();
    if (m_gnt !== 2'b01) begin failures++; $display("FAIL rstmid_ptr: got %b want 01", m_gnt); end checks++;
    advance();
    m_req = '0;
    settle();
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int m = 0; m < NM; m++) begin
        if (m != lock_m) begin
          m_req[m]          = 1'($urandom);
          m_addr[m*32 +: 32] = rand_addr();
          m_we[m]           = 1'($urandom);
          m_be[m*4 +: 4]    = 4'($urandom);
          m_wdata[m*32 +: 32] = $urandom;
        end
      end
      s_gnt = 2'($urandom);
      settle();
      if (m_gnt !== exp_gnt || s_req !== exp_sreq) begin failures++; $display("FAIL rnd_gnt[%0d]: got gnt=%b sreq=%b want %b/%b", n, m_gnt, s_req, exp_gnt, exp_sreq); end checks++;
      if (m_rvalid !== exp_rvalid || m_rdata !== exp_rdata || m_err !== exp_err) begin failures++; $display("FAIL rnd_resp[%0d]: got %b/%h/%b want %b/%h/%b", n, m_rvalid, m_rdata, m_err, exp_rvalid, exp_rdata, exp_err); end checks++;
      if (w_m >= 0) begin
        if (s_addr !== exp_saddr || s_we !== exp_swe || s_be !== exp_sbe || s_wdata !== exp_swdata) begin failures++; $display("FAIL rnd_bcast[%0d]: got %h/%b/%b/%h want %h/%b/%b/%h", n, s_addr, s_we, s_be, s_wdata, exp_saddr, exp_swe, exp_sbe, exp_swdata); end checks++;
      end
      advance();
    end
    m_req = '0;
    settle();
    if (m_rvalid !== exp_rvalid) begin failures++; $display("FAIL rnd_drain: got %b want %b", m_rvalid, exp_rvalid); end checks++;
    advance();
  endtask

  initial begin
    rst_n = 1'b0; m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
    s_gnt = '0; s_rdata = '0;
    ptr_m = 0; lock_m = -1; pend_v = 1'b0; pend_m = 0; pend_s = 0;
    w_m = -1; sl_m = -1; g_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_unmapped();
    test_write();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
